// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parity modes, receiver FSM states and the 2-of-3 majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic logic maj3(input logic a,
                                  input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO for uart_rx_param.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    // Storage is not reset; equal pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

    // Read and write pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-voted sampling.
// Define UART_RX_FIFO_EN to add a FWFT receive FIFO with rd_ack pop.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_rd,
    input  logic                 sample_en,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] T_A    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_B    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_C    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_FULL = BW'(DATA_BITS);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam parity_t       PMODE  = parity_t'(2'(PARITY));

    logic                 s1, s2, s3;
    logic                 rx, fall;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic                 stop_cnt, stop_n;
    logic [1:0]           smp, smp_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 vote, deliver, ferr;

    // Synchronise the line; reset low so a line already low never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= data_rd;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rx   = s2;
    assign fall = s3 & ~s2;

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            smp      <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            smp      <= smp_n;
            shreg    <= shreg_n;
            perr     <= perr_n;
        end
    end

    // Bit timing, 3-sample voting, word assembly and frame checks.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        stop_n  = stop_cnt;
        smp_n   = smp;
        shreg_n = shreg;
        perr_n  = perr;
        deliver = 1'b0;
        ferr    = 1'b0;
        vote    = maj3(smp[0], smp[1], rx);
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_WAIT_IDLE: begin
                if (sample_en) begin
                    if (!rx) begin
                        cnt_n = '0;
                    end else if (cnt == T_LAST) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (sample_en) begin
                    cnt_n = (cnt == T_LAST) ? '0 : cnt + 1'b1;
                    if (cnt == T_A) smp_n[0] = rx;
                    if (cnt == T_B) smp_n[1] = rx;
                    if (cnt == T_C) begin
                        unique case (1'b1)
                            state == ST_START: begin
                                if (vote) begin
                                    state_n = ST_IDLE;
                                end else begin
                                    state_n = ST_DATA;
                                    bit_n   = '0;
                                    stop_n  = 1'b0;
                                    perr_n  = 1'b0;
                                end
                            end
                            state == ST_DATA: begin
                                shreg_n = {vote, shreg[DATA_BITS-1:1]};
                                if (bit_cnt != B_FULL) bit_n = bit_cnt + 1'b1;
                                if (bit_cnt == B_LAST)
                                    state_n = (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end
                            state == ST_PARITY: begin
                                perr_n  = (^shreg) ^ vote ^ (PMODE == PAR_ODD);
                                state_n = ST_STOP;
                            end
                            default: begin
                                if (!vote) begin
                                    ferr    = 1'b1;
                                    state_n = ST_WAIT_IDLE;
                                    cnt_n   = '0;
                                end else if (stop_cnt == S_LAST) begin
                                    deliver = 1'b1;
                                    state_n = ST_IDLE;
                                end else begin
                                    stop_n = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign rx_busy = (state == ST_DATA) || (state == ST_PARITY) ||
                     (state == ST_STOP);

    // Framing error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= ferr;
    end

`ifdef UART_RX_FIFO_EN
    logic               full, empty;
    logic [DATA_BITS:0] head;

    uart_rx_fifo #(
        .WIDTH(DATA_BITS + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (deliver),
        .din  ({perr, shreg}),
        .pop  (rd_ack),
        .dout (head),
        .empty(empty),
        .full (full)
    );

    assign dataout    = empty ? '0 : head[DATA_BITS-1:0];
    assign parity_err = empty ? 1'b0 : head[DATA_BITS];
    assign data_valid = ~empty;

    // A word arriving into a full FIFO with no pop is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else        overrun <= deliver & full & ~rd_ack;
    end
`else
    logic unused_cfg;
    assign unused_cfg = rd_ack & (FIFO_DEPTH > 1);
    assign overrun    = 1'b0;

    // Hold the last good word and pulse valid per delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout    <= '0;
            parity_err <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= deliver;
            if (deliver) begin
                dataout    <= shreg;
                parity_err <= perr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 and 8E1 instances on one clock.
// The FIFO sequence runs only when UART_RX_FIFO_EN is defined.
module tb_uart_rx_param;

    typedef struct {
        bit         sel;
        logic [7:0] word;
        bit         pbit;
        bit         stop;
        int         exp_valid;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    localparam int NV = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       se = 1'b0;
    logic       line = 1'b1;
    logic       sel = 1'b0;
    logic       auto_pop = 1'b1;
    logic       man_pop = 1'b0;
    logic       pop_a = 1'b0;
    logic       pop_b = 1'b0;
    logic       rd_a;
    logic [7:0] dout_a, dout_b;
    logic       dv_a, pe_a, fe_a, ov_a, bz_a;
    logic       dv_b, pe_b, fe_b, ov_b, bz_b;

    int   errors = 0;
    int   checks = 0;
    int   qa[$];
    int   qb[$];
    int   fe_cnt_a = 0, fe_cnt_b = 0, ov_cnt_a = 0;
    bit   busy_a = 0, busy_b = 0;
    vec_t tv[NV];
    int   got, w;

    assign rd_a = auto_pop ? pop_a : man_pop;

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .data_rd(sel ? 1'b1 : line),
        .sample_en(se), .rd_ack(rd_a),
        .dataout(dout_a), .data_valid(dv_a),
        .parity_err(pe_a), .frame_err(fe_a),
        .overrun(ov_a), .rx_busy(bz_a)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .data_rd(sel ? line : 1'b1),
        .sample_en(se), .rd_ack(pop_b),
        .dataout(dout_b), .data_valid(dv_b),
        .parity_err(pe_b), .frame_err(fe_b),
        .overrun(ov_b), .rx_busy(bz_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            se = 1'b1;
            @(negedge clk);
            se = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        forever begin
            @(negedge clk);
`ifdef UART_RX_FIFO_EN
            pop_a = auto_pop && dv_a;
            if (pop_a) qa.push_back(int'({pe_a, dout_a}));
            pop_b = dv_b;
            if (pop_b) qb.push_back(int'({pe_b, dout_b}));
`else
            if (dv_a) qa.push_back(int'({pe_a, dout_a}));
            if (dv_b) qb.push_back(int'({pe_b, dout_b}));
`endif
            if (fe_a) fe_cnt_a++;
            if (fe_b) fe_cnt_b++;
            if (ov_a) ov_cnt_a++;
            if (bz_a) busy_a = 1;
            if (bz_b) busy_b = 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!se) @(posedge clk);
        end
    endtask

    task automatic hold(input logic v, input int n);
        #1 line = v;
        ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] wd, input bit par_en,
                              input bit pbit, input bit stop,
                              input int spike);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == spike) begin
                hold(1'b0, 8);
                hold(1'b1, 1);
                hold(1'b0, 7);
            end else begin
                hold(wd[i], 16);
            end
        end
        if (par_en) hold(pbit, 16);
        hold(stop, 16);
        #1 line = 1'b1;
    endtask

    task automatic clear();
        qa.delete();
        qb.delete();
        fe_cnt_a = 0;
        fe_cnt_b = 0;
        ov_cnt_a = 0;
        busy_a = 0;
        busy_b = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " dataout"}, int'(dout_a), 0);
        chk({tag, " data_valid"}, int'(dv_a), 0);
        chk({tag, " parity_err"}, int'(pe_a), 0);
        chk({tag, " frame_err"}, int'(fe_a), 0);
        chk({tag, " overrun"}, int'(ov_a), 0);
        chk({tag, " rx_busy"}, int'(bz_a), 0);
    endtask

    initial begin
        logic [7:0] fexp [4];
        fexp[0] = 8'h11; fexp[1] = 8'h22; fexp[2] = 8'h33; fexp[3] = 8'h44;

        tv[0]  = '{0, 8'hA5, 0, 1, 1, 0, 0};
        tv[1]  = '{0, 8'h3C, 0, 1, 1, 0, 0};
        tv[2]  = '{0, 8'hFF, 0, 1, 1, 0, 0};
        tv[3]  = '{0, 8'h01, 0, 1, 1, 0, 0};
        tv[4]  = '{0, 8'h80, 0, 1, 1, 0, 0};
        tv[5]  = '{0, 8'h5A, 0, 0, 0, 0, 1};
        tv[6]  = '{1, 8'h07, 0, 1, 1, 1, 0};
        tv[7]  = '{1, 8'h07, 1, 1, 1, 0, 0};
        tv[8]  = '{1, 8'h03, 0, 1, 1, 0, 0};
        tv[9]  = '{1, 8'h03, 1, 1, 1, 1, 0};
        tv[10] = '{1, 8'h11, 0, 0, 0, 0, 1};

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        ticks(40);

        for (int i = 0; i < NV; i++) begin
            clear();
            sel = tv[i].sel;
            send_frame(tv[i].word, tv[i].sel, tv[i].pbit, tv[i].stop, -1);
            ticks(32);
            got = sel ? qb.size() : qa.size();
            chk($sformatf("vec%0d valid", i), got, tv[i].exp_valid);
            if (got > 0) begin
                w = sel ? qb[0] : qa[0];
                chk($sformatf("vec%0d word", i), w & 255, int'(tv[i].word));
                chk($sformatf("vec%0d parity_err", i), w >> 8, tv[i].exp_perr);
            end
            chk($sformatf("vec%0d frame_err", i),
                sel ? fe_cnt_b : fe_cnt_a, tv[i].exp_ferr);
            chk($sformatf("vec%0d busy", i), int'(sel ? busy_b : busy_a), 1);
        end
        sel = 1'b0;

        clear();
        send_frame(8'hA5, 0, 0, 1, -1);
        send_frame(8'h3C, 0, 0, 1, -1);
        ticks(32);
        chk("b2b count", qa.size(), 2);
        if (qa.size() == 2) begin
            chk("b2b first", qa[0], 'h0A5);
            chk("b2b second", qa[1], 'h03C);
        end
        chk("b2b frame_err", fe_cnt_a, 0);
`ifndef UART_RX_FIFO_EN
        @(negedge clk);
        chk("hold dataout", int'(dout_a), 'h3C);
        chk("hold valid low", int'(dv_a), 0);
`endif

        clear();
        hold(1'b0, 4);
        hold(1'b1, 40);
        chk("glitch busy", int'(busy_a), 0);
        chk("glitch words", qa.size(), 0);
        chk("glitch frame_err", fe_cnt_a, 0);

        clear();
        send_frame(8'h00, 0, 0, 1, 3);
        ticks(32);
        chk("spike count", qa.size(), 1);
        if (qa.size() > 0) chk("spike word", qa[0], 0);

        clear();
        hold(1'b0, 480);
        hold(1'b1, 40);
        chk("break frame_err", fe_cnt_a, 1);
        chk("break words", qa.size(), 0);
        clear();
        send_frame(8'h55, 0, 0, 1, -1);
        ticks(32);
        chk("after break count", qa.size(), 1);
        if (qa.size() > 0) chk("after break word", qa[0], 'h055);

        clear();
        fork
            send_frame(8'h81, 0, 0, 1, -1);
            begin
                ticks(72);
                @(negedge clk);
                chk("busy before reset", int'(bz_a), 1);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                chk_reset_outputs("midreset");
                rst_n = 1'b1;
            end
        join
        ticks(32);
        chk("aborted words", qa.size(), 0);
        chk("aborted frame_err", fe_cnt_a, 0);
        chk("aborted busy", int'(bz_a), 0);
        clear();
        send_frame(8'h81, 0, 0, 1, -1);
        ticks(32);
        chk("post reset count", qa.size(), 1);
        if (qa.size() > 0) chk("post reset word", qa[0], 'h081);

`ifdef UART_RX_FIFO_EN
        auto_pop = 1'b0;
        clear();
        for (int i = 0; i < 4; i++) begin
            send_frame(fexp[i], 0, 0, 1, -1);
            ticks(16);
        end
        chk("fifo no overrun", ov_cnt_a, 0);
        send_frame(8'h55, 0, 0, 1, -1);
        ticks(32);
        chk("fifo overrun", ov_cnt_a, 1);
        @(negedge clk);
        chk("fifo valid", int'(dv_a), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo pop%0d", i), int'(dout_a), int'(fexp[i]));
            man_pop = 1'b1;
            @(negedge clk);
            man_pop = 1'b0;
        end
        chk("fifo empty", int'(dv_a), 0);
        auto_pop = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
